regfile_write_ctrl: RTL and testbench

Write-port controller for the `registers` register file. It arbitrates three write-back requesters (ALU, LOAD, MUL) onto the file's single write port. It drives `regwrite`, `write_reg`, `write_data` and the four NZCV flag inputs. It also keeps a pending-write scoreboard that stalls issue on read-after-write and write-after-write hazards. It sits between the execute/memory stages and the register file.

---
 rtl/regfile_write_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_regfile_write_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_ctrl.sv
// Write-port controller: arbitrates ALU/LOAD/MUL write-backs onto the register file port and tracks pending writes.
// Latency: combinational ack; regwrite/write_reg/write_data/flags registered one cycle after the grant edge.
// Backpressure: losing requesters hold req with ack low; issue is held off (issue_ready low) while a RAW/WAW hazard exists.
//
// Optional feature macro: RR_ARB_EN
//   defined   -> round-robin arbitration ALU->LOAD->MUL->ALU, with a 2-bit pointer.
//   undefined -> fixed priority LOAD > ALU > MUL, with no pointer state.
//
// Ports:
//   clock, reset                       rising-edge clock, asynchronous active-high reset
//   {alu,ld,mul}_req/_rd/_data/_ack    write-back requesters (ack is a combinational grant)
//   alu_flag_we, alu_nzcv              ALU flag update request
//   issue_valid/_wr/_rd/_rs1/_rs2      decode issue interface
//   issue_ready, stall                 hazard result for the presented instruction
//   regwrite, write_reg, write_data    registered register-file write port
//   negative/zero/carry/overflow_flag  registered, held NZCV into the register file
//   busy                               pending-write scoreboard (debug)
module regfile_write_ctrl #(
    parameter int NREG   = 16,
    parameter int RNUM_W = 4
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              alu_req,
    input  logic [RNUM_W-1:0] alu_rd,
    input  logic [31:0]       alu_data,
    input  logic              alu_flag_we,
    input  logic [3:0]        alu_nzcv,
    output logic              alu_ack,

    input  logic              ld_req,
    input  logic [RNUM_W-1:0] ld_rd,
    input  logic [31:0]       ld_data,
    output logic              ld_ack,

    input  logic              mul_req,
    input  logic [RNUM_W-1:0] mul_rd,
    input  logic [31:0]       mul_data,
    output logic              mul_ack,

    input  logic              issue_valid,
    input  logic              issue_wr,
    input  logic [RNUM_W-1:0] issue_rd,
    input  logic [RNUM_W-1:0] issue_rs1,
    input  logic [RNUM_W-1:0] issue_rs2,
    output logic              issue_ready,
    output logic              stall,

    output logic              regwrite,
    output logic [31:0]       write_reg,
    output logic [31:0]       write_data,
    output logic              negative_flag,
    output logic              zero_flag,
    output logic              carry_flag,
    output logic              overflow_flag,
    output logic [NREG-1:0]   busy
);

    // Requester indices, also the encoding of the round-robin pointer.
    localparam logic [1:0] REQ_ALU = 2'd0;
    localparam logic [1:0] REQ_LD  = 2'd1;
    localparam logic [1:0] REQ_MUL = 2'd2;

    logic              w_gnt_alu;
    logic              w_gnt_ld;
    logic              w_gnt_mul;
    logic              w_any_gnt;
    logic [RNUM_W-1:0] w_gnt_rd;
    logic [31:0]       w_gnt_data;

    logic [NREG-1:0]   r_busy;
    logic [NREG-1:0]   w_set_mask;
    logic [NREG-1:0]   w_clr_mask;
    logic              w_issue_fire;

`ifdef RR_ARB_EN
    // Pointer names the requester searched first; it moves to the one after
    // each winner, so a requester waits behind at most the other two.
    logic [1:0] r_rr_ptr;

    always_comb begin
        w_gnt_alu = 1'b0;
        w_gnt_ld  = 1'b0;
        w_gnt_mul = 1'b0;
        case (r_rr_ptr)
            REQ_ALU: begin
                if (alu_req)      w_gnt_alu = 1'b1;
                else if (ld_req)  w_gnt_ld  = 1'b1;
                else if (mul_req) w_gnt_mul = 1'b1;
            end
            REQ_LD: begin
                if (ld_req)       w_gnt_ld  = 1'b1;
                else if (mul_req) w_gnt_mul = 1'b1;
                else if (alu_req) w_gnt_alu = 1'b1;
            end
            default: begin
                if (mul_req)      w_gnt_mul = 1'b1;
                else if (alu_req) w_gnt_alu = 1'b1;
                else if (ld_req)  w_gnt_ld  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rr_ptr <= REQ_ALU;
        end else if (w_gnt_alu) begin
            r_rr_ptr <= REQ_LD;
        end else if (w_gnt_ld) begin
            r_rr_ptr <= REQ_MUL;
        end else if (w_gnt_mul) begin
            r_rr_ptr <= REQ_ALU;
        end
    end
`else
    // Fixed priority: LOAD first, then ALU, then MUL.
    always_comb begin
        w_gnt_ld  = ld_req;
        w_gnt_alu = alu_req & ~ld_req;
        w_gnt_mul = mul_req & ~ld_req & ~alu_req;
    end
`endif

    // No grant may be seen while reset is held, even with requests high.
    assign alu_ack = w_gnt_alu & ~reset;
    assign ld_ack  = w_gnt_ld  & ~reset;
    assign mul_ack = w_gnt_mul & ~reset;

    assign w_any_gnt = alu_ack | ld_ack | mul_ack;

    always_comb begin
        w_gnt_rd   = alu_rd;
        w_gnt_data = alu_data;
        if (ld_ack) begin
            w_gnt_rd   = ld_rd;
            w_gnt_data = ld_data;
        end else if (mul_ack) begin
            w_gnt_rd   = mul_rd;
            w_gnt_data = mul_data;
        end
    end

    // Write stage: enable pulses per grant, address/data hold between grants.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            regwrite   <= 1'b0;
            write_reg  <= 32'd0;
            write_data <= 32'd0;
        end else begin
            regwrite <= w_any_gnt;
            if (w_any_gnt) begin
                write_reg  <= {{(32-RNUM_W){1'b0}}, w_gnt_rd};
                write_data <= w_gnt_data;
            end
        end
    end

    // Only an ALU grant carrying a flag update changes NZCV.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            negative_flag <= 1'b0;
            zero_flag     <= 1'b0;
            carry_flag    <= 1'b0;
            overflow_flag <= 1'b0;
        end else if (alu_ack && alu_flag_we) begin
            negative_flag <= alu_nzcv[3];
            zero_flag     <= alu_nzcv[2];
            carry_flag    <= alu_nzcv[1];
            overflow_flag <= alu_nzcv[0];
        end
    end

    // Hazard detection against the pending-write bitmap.
    assign stall       = r_busy[issue_rs1] | r_busy[issue_rs2] | (issue_wr & r_busy[issue_rd]);
    assign issue_ready = issue_valid & ~stall;

    assign w_issue_fire = issue_ready & issue_wr;
    assign w_set_mask   = w_issue_fire ? ({{(NREG-1){1'b0}}, 1'b1} << issue_rd) : '0;
    assign w_clr_mask   = w_any_gnt    ? ({{(NREG-1){1'b0}}, 1'b1} << w_gnt_rd) : '0;

    // Clear is applied before set so a same-edge issue to the granted
    // register leaves it pending for the newer writer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
        end
    end

    assign busy = r_busy;

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Directed bench for regfile_write_ctrl: reset, arbitration order, write stage, flags, scoreboard hazards, async reset.
// Latency: checks combinational acks mid-cycle and registered outputs 1 ns after the rising edge.
// Backpressure: exercises contention (losers held) and RAW/WAW issue stalls.
module tb_regfile_write_ctrl;

    logic        clock;
    logic        reset;
    logic        alu_req, ld_req, mul_req;
    logic [3:0]  alu_rd, ld_rd, mul_rd;
    logic [31:0] alu_data, ld_data, mul_data;
    logic        alu_flag_we;
    logic [3:0]  alu_nzcv;
    logic        alu_ack, ld_ack, mul_ack;
    logic        issue_valid, issue_wr;
    logic [3:0]  issue_rd, issue_rs1, issue_rs2;
    logic        issue_ready, stall;
    logic        regwrite;
    logic [31:0] write_reg, write_data;
    logic        negative_flag, zero_flag, carry_flag, overflow_flag;
    logic [15:0] busy;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_write_ctrl #(.NREG(16), .RNUM_W(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .alu_req       (alu_req),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .alu_flag_we   (alu_flag_we),
        .alu_nzcv      (alu_nzcv),
        .alu_ack       (alu_ack),
        .ld_req        (ld_req),
        .ld_rd         (ld_rd),
        .ld_data       (ld_data),
        .ld_ack        (ld_ack),
        .mul_req       (mul_req),
        .mul_rd        (mul_rd),
        .mul_data      (mul_data),
        .mul_ack       (mul_ack),
        .issue_valid   (issue_valid),
        .issue_wr      (issue_wr),
        .issue_rd      (issue_rd),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .issue_ready   (issue_ready),
        .stall         (stall),
        .regwrite      (regwrite),
        .write_reg     (write_reg),
        .write_data    (write_data),
        .negative_flag (negative_flag),
        .zero_flag     (zero_flag),
        .carry_flag    (carry_flag),
        .overflow_flag (overflow_flag),
        .busy          (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] acks();
        return {29'd0, mul_ack, ld_ack, alu_ack};
    endfunction

    function automatic logic [31:0] nzcv();
        return {28'd0, negative_flag, zero_flag, carry_flag, overflow_flag};
    endfunction

    // Requester index 0=ALU 1=LOAD 2=MUL for the contention table.
    logic [3:0]  c_rd   [3];
    logic [31:0] c_data [3];
    int          order  [3];

    initial begin
        c_rd[0] = 4'd1;  c_data[0] = 32'hA1A1_0001;
        c_rd[1] = 4'd2;  c_data[1] = 32'hB2B2_0002;
        c_rd[2] = 4'd3;  c_data[2] = 32'hC3C3_0003;
`ifdef RR_ARB_EN
        order[0] = 0; order[1] = 1; order[2] = 2;
`else
        order[0] = 1; order[1] = 0; order[2] = 2;
`endif

        // Reset held with every requester asking.
        reset       = 1'b1;
        alu_req = 1'b1; alu_rd = c_rd[0]; alu_data = c_data[0];
        ld_req  = 1'b1; ld_rd  = c_rd[1]; ld_data  = c_data[1];
        mul_req = 1'b1; mul_rd = c_rd[2]; mul_data = c_data[2];
        alu_flag_we = 1'b0; alu_nzcv = 4'b0;
        issue_valid = 1'b0; issue_wr = 1'b0;
        issue_rd = 4'd0; issue_rs1 = 4'd7; issue_rs2 = 4'd8;
        @(posedge clock); #1;
        check("rst_acks",     acks(),           32'd0);
        check("rst_regwrite", 32'(regwrite),    32'd0);
        check("rst_busy",     32'(busy),        32'd0);
        check("rst_flags",    nzcv(),           32'd0);
        check("rst_wreg",     write_reg,        32'd0);
        check("rst_wdata",    write_data,       32'd0);

        // Contention: three back-to-back grants in policy order.
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("cont_ack", acks(), 32'd1 << order[i]);
            @(posedge clock); #1;
            check("cont_regwrite", 32'(regwrite), 32'd1);
            check("cont_wreg",     write_reg,     32'(c_rd[order[i]]));
            check("cont_wdata",    write_data,    c_data[order[i]]);
            @(negedge clock);
            case (order[i])
                0:       alu_req = 1'b0;
                1:       ld_req  = 1'b0;
                default: mul_req = 1'b0;
            endcase
        end
        #1;
        check("cont_idle_acks", acks(), 32'd0);
        @(posedge clock); #1;
        check("cont_regwrite_end", 32'(regwrite), 32'd0);
        check("cont_busy",         32'(busy),     32'd0);

        // Single ALU write with flag update.
        @(negedge clock);
        alu_req = 1'b1; alu_rd = 4'd2; alu_data = 32'h1234_5678;
        alu_flag_we = 1'b1; alu_nzcv = 4'b0100;
        #1;
        check("alu_ack", acks(), 32'd1);
        @(posedge clock); #1;
        check("alu_regwrite", 32'(regwrite), 32'd1);
        check("alu_wreg",     write_reg,     32'd2);
        check("alu_wdata",    write_data,    32'h1234_5678);
        check("alu_flags",    nzcv(),        32'h4);
        @(negedge clock);
        alu_req = 1'b0; alu_flag_we = 1'b0; alu_nzcv = 4'b1111;
        @(posedge clock); #1;
        check("alu_regwrite_off", 32'(regwrite), 32'd0);
        check("alu_wdata_hold",   write_data,    32'h1234_5678);
        check("alu_flags_hold",   nzcv(),        32'h4);

        // RAW: producer to r0, then a consumer of r0 stalls until the load commits.
        @(negedge clock);
        issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 4'd0; issue_rs1 = 4'd7; issue_rs2 = 4'd8;
        #1;
        check("raw_issue0_ready", 32'(issue_ready), 32'd1);
        @(posedge clock); #1;
        check("raw_busy0", 32'(busy), 32'h0001);
        @(negedge clock);
        issue_wr = 1'b0; issue_rs1 = 4'd0;
        #1;
        check("raw_stall",   32'(stall),       32'd1);
        check("raw_ready0",  32'(issue_ready), 32'd0);
        @(posedge clock); #1;
        check("raw_stall_hold", 32'(stall), 32'd1);
        @(negedge clock);
        ld_req = 1'b1; ld_rd = 4'd0; ld_data = 32'hABCD_EF01;
        #1;
        check("raw_ld_ack",    acks(),        32'd2);
        check("raw_ready_pre", 32'(issue_ready), 32'd0);
        @(posedge clock); #1;
        check("raw_busy_clr",  32'(busy),        32'd0);
        check("raw_ready",     32'(issue_ready), 32'd1);
        check("raw_stall_clr", 32'(stall),       32'd0);
        check("raw_wdata",     write_data,       32'hABCD_EF01);
        check("raw_wreg",      write_reg,        32'd0);
        check("raw_flags_kept", nzcv(),          32'h4);
        @(negedge clock);
        ld_req = 1'b0; issue_valid = 1'b0; issue_rs1 = 4'd7;

        // Set wins: issue to r5 on the same edge a MUL write to r5 is granted.
        @(negedge clock);
        issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 4'd5;
        mul_req = 1'b1; mul_rd = 4'd5; mul_data = 32'h0000_0555;
        #1;
        check("sw_ready",   32'(issue_ready), 32'd1);
        check("sw_mul_ack", acks(),           32'd4);
        @(posedge clock); #1;
        check("sw_busy",   32'(busy),  32'h0020);
        check("sw_wreg",   write_reg,  32'd5);
        @(negedge clock);
        mul_req = 1'b0;
        #1;
        check("waw_stall", 32'(stall),       32'd1);
        check("waw_ready", 32'(issue_ready), 32'd0);
        issue_rd = 4'd2;
        #1;
        check("waw_other_ready", 32'(issue_ready), 32'd1);
        @(posedge clock); #1;
        check("busy_0024", 32'(busy), 32'h0024);

        // Asynchronous reset mid-burst.
        @(negedge clock);
        issue_valid = 1'b0; issue_wr = 1'b0;
        alu_req = 1'b1; alu_rd = 4'd9; alu_data = 32'h9999_0009;
        @(posedge clock); #1;
        check("ar_regwrite_pre", 32'(regwrite), 32'd1);
        check("ar_busy_pre",     32'(busy),     32'h0024);
        #2;
        reset = 1'b1;
        #1;
        check("ar_busy",     32'(busy),     32'd0);
        check("ar_regwrite", 32'(regwrite), 32'd0);
        check("ar_acks",     acks(),        32'd0);
        check("ar_wreg",     write_reg,     32'd0);
        check("ar_flags",    nzcv(),        32'd0);
        @(negedge clock);
        reset = 1'b0;
        alu_req = 1'b0;
        @(posedge clock); #1;
        check("ar_post_regwrite", 32'(regwrite), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
